// File: rtl/v_zone_spi_tx_pkg.sv
// Shared types and constants for the vertical-zone SPI transmitter.
package v_zone_spi_tx_pkg;

  typedef enum logic [2:0] {IDLE, HDR, RD, WT, SH, CRC, LAT, GAP} state_t;

  localparam logic [3:0] ADDR_BLANK = 4'd15;
  localparam logic [7:0] CRC8_POLY  = 8'h07;

  // One MSB-first CRC-8 step for a single serial bit.
  function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/v_zone_spi_tx_if.sv
// Duty-buffer read port and LED-driver serial pins of the zone transmitter.
interface v_zone_spi_tx_if #(
  parameter int COL_W  = 3,
  parameter int DUTY_W = 8
);
  logic [4+COL_W-1:0] oRd_Addr;
  logic               oRd_En;
  logic [DUTY_W-1:0]  iRd_Data;
  logic               oSCLK;
  logic               oSDO;
  logic               oCS_n;
  logic               oLatch;

  modport master (output oRd_Addr, oRd_En, oSCLK, oSDO, oCS_n, oLatch,
                  input  iRd_Data);
  modport slave  (input  oRd_Addr, oRd_En, oSCLK, oSDO, oCS_n, oLatch,
                  output iRd_Data);
endinterface

// File: rtl/v_zone_sclk_gen.sv
// SCLK divider: each bit is SCLK_HALF low cycles then SCLK_HALF high cycles.
module v_zone_sclk_gen #(
  parameter int SCLK_HALF = 2
) (
  input  logic iODCK,
  input  logic iVSYNC_Preframe_rst,
  input  logic en,
  output logic bitStart,
  output logic bitEnd,
  output logic oSCLK
);
  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [CW-1:0] cnt;
  logic          ph;
  logic          wrap;

  assign wrap = (cnt == CW'(SCLK_HALF - 1));

  // Disabled means parked at the start of a low phase, so re-enable begins a fresh bit.
  always_ff @(posedge iODCK or posedge iVSYNC_Preframe_rst) begin
    if (iVSYNC_Preframe_rst) begin
      cnt <= '0;
      ph  <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      ph  <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      ph  <= ~ph;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign oSCLK    = ph;
  assign bitStart = en && !ph && (cnt == '0);
  assign bitEnd   = en && ph && wrap;

endmodule

// File: rtl/v_zone_spi_tx.sv
// Scanning-backlight row transmitter: on entry to zone row 0..14 it reads the row's
// duties and sends {HDR_TAG,row} + duties as one SPI frame, then latches. CRC option: V_ZONE_TX_CRC8_EN.
module v_zone_spi_tx
  import v_zone_spi_tx_pkg::*;
#(
  parameter int         H_ZONES   = 8,
  parameter int         COL_W     = 3,
  parameter int         DUTY_W    = 8,
  parameter int         SCLK_HALF = 2,
  parameter logic [3:0] HDR_TAG   = 4'hA
) (
  input  logic              iODCK,
  input  logic              iVSYNC_Preframe_rst,
  input  logic [3:0]        iV_Address,
  v_zone_spi_tx_if.master   bus,
  output logic              oBusy,
  output logic              oOverrun
);
  localparam int SW  = (DUTY_W > 8) ? DUTY_W : 8;
  localparam int BCW = $clog2(SW) + 1;
`ifdef V_ZONE_TX_CRC8_EN
  localparam state_t TAIL = CRC;
`else
  localparam state_t TAIL = LAT;
`endif

  state_t           state, nxt;
  logic [3:0]       prevAddr, row, pendRow, rowSel;
  logic             pendVld;
  logic [COL_W-1:0] col;
  logic [BCW-1:0]   bitCnt;
  logic [SW-1:0]    shreg;
  logic             bitStart, bitEnd, sclkEn, segDone, lastCol;
  logic             trig, launch, launchNew, capture;

  v_zone_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk (
    .iODCK              (iODCK),
    .iVSYNC_Preframe_rst(iVSYNC_Preframe_rst),
    .en                 (sclkEn),
    .bitStart           (bitStart),
    .bitEnd             (bitEnd),
    .oSCLK              (bus.oSCLK)
  );

  assign trig      = (iV_Address != prevAddr) && (iV_Address != ADDR_BLANK);
  assign sclkEn    = (state == HDR) || (state == SH) || (state == CRC);
  // bitCnt counts bits started, so the segment ends on the bitEnd where it reached full length.
  assign segDone   = bitEnd && (bitCnt == ((state == SH) ? BCW'(DUTY_W) : BCW'(8)));
  assign lastCol   = (col == COL_W'(H_ZONES - 1));
  assign rowSel    = pendVld ? pendRow : iV_Address;
  assign launch    = (nxt == HDR) && ((state == IDLE) || (state == GAP));
  assign launchNew = launch && !pendVld;
  assign capture   = trig && !launchNew;

  always_comb begin
    nxt          = state;
    oBusy        = 1'b1;
    bus.oCS_n    = 1'b1;
    bus.oLatch   = 1'b0;
    bus.oRd_En   = 1'b0;
    case (state)
      IDLE: begin
        oBusy = 1'b0;
        if (trig || pendVld) nxt = HDR;
      end
      HDR: begin
        bus.oCS_n = 1'b0;
        if (segDone) nxt = RD;
      end
      RD: begin
        bus.oCS_n  = 1'b0;
        bus.oRd_En = 1'b1;
        nxt        = WT;
      end
      WT: begin
        bus.oCS_n = 1'b0;
        nxt       = SH;
      end
      SH: begin
        bus.oCS_n = 1'b0;
        if (segDone) nxt = lastCol ? TAIL : RD;
      end
      CRC: begin
        bus.oCS_n = 1'b0;
        if (segDone) nxt = LAT;
      end
      LAT: begin
        bus.oLatch = 1'b1;
        nxt        = GAP;
      end
      GAP: begin
        oBusy = 1'b0;
        nxt   = pendVld ? HDR : IDLE;
      end
      default: begin
        oBusy = 1'b0;
        nxt   = IDLE;
      end
    endcase
  end

  assign bus.oRd_Addr = {row, col};
  assign bus.oSDO     = shreg[SW-1];

  // A launch from pending frees the slot, so a same-cycle trigger refills it without overrun.
  always_ff @(posedge iODCK or posedge iVSYNC_Preframe_rst) begin
    if (iVSYNC_Preframe_rst) begin
      state    <= IDLE;
      prevAddr <= ADDR_BLANK;
      row      <= '0;
      pendRow  <= '0;
      pendVld  <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      state    <= nxt;
      prevAddr <= iV_Address;
      if (launch) row <= rowSel;
      if (capture) begin
        pendRow <= iV_Address;
        pendVld <= 1'b1;
        if (pendVld && !launch) oOverrun <= 1'b1;
      end else if (launch && pendVld) begin
        pendVld <= 1'b0;
      end
    end
  end

`ifdef V_ZONE_TX_CRC8_EN
  logic [7:0] crc, crcNext;
  assign crcNext = crc8Step(crc, shreg[SW-1]);

  always_ff @(posedge iODCK or posedge iVSYNC_Preframe_rst) begin
    if (iVSYNC_Preframe_rst)                         crc <= '0;
    else if (launch)                                 crc <= '0;
    else if (bitEnd && ((state == HDR) || (state == SH))) crc <= crcNext;
  end
`endif

  always_ff @(posedge iODCK or posedge iVSYNC_Preframe_rst) begin
    if (iVSYNC_Preframe_rst) begin
      shreg  <= '0;
      col    <= '0;
      bitCnt <= '0;
    end else if (launch) begin
      shreg  <= SW'({HDR_TAG, rowSel}) << (SW - 8);
      col    <= '0;
      bitCnt <= '0;
    end else begin
      if (bitStart)     bitCnt <= bitCnt + 1'b1;
      else if (segDone) bitCnt <= '0;
      if (state == WT)
        shreg <= SW'(bus.iRd_Data) << (SW - DUTY_W);
`ifdef V_ZONE_TX_CRC8_EN
      else if (segDone && (state == SH) && lastCol)
        shreg <= SW'(crcNext) << (SW - 8);
`endif
      else if (bitEnd)
        shreg <= shreg << 1;
      if (segDone && (state == SH) && !lastCol) col <= col + 1'b1;
    end
  end

endmodule

// File: tb/tb_v_zone_spi_tx.sv
// Directed bench for v_zone_spi_tx: vector table of rows plus hand-written corner sequences.
module tb_v_zone_spi_tx;
`ifdef V_ZONE_TX_CRC8_EN
  localparam int NB = 80;
`else
  localparam int NB = 72;
`endif

  logic       iODCK = 1'b0;
  logic       iVSYNC_Preframe_rst = 1'b1;
  logic [3:0] iV_Address = 4'd15;
  logic       oBusy, oOverrun;

  v_zone_spi_tx_if #(.COL_W(3), .DUTY_W(8)) bus ();

  v_zone_spi_tx dut (
    .iODCK              (iODCK),
    .iVSYNC_Preframe_rst(iVSYNC_Preframe_rst),
    .iV_Address         (iV_Address),
    .bus                (bus.master),
    .oBusy              (oBusy),
    .oOverrun           (oOverrun)
  );

  always #5 iODCK = ~iODCK;

  logic [7:0] mem [0:15][0:7];

  always @(posedge iODCK)
    if (bus.oRd_En) bus.iRd_Data <= mem[bus.oRd_Addr[6:3]][bus.oRd_Addr[2:0]];

  typedef struct { int nb; logic [0:127] bits; } frame_t;
  frame_t       frames[$];
  int           capN = 0;
  int           latchCnt = 0;
  logic [0:127] capBits = '0;
  logic         sclkPrev = 1'b0;

  // Receiver model: samples SDO on each SCLK rise while selected, closes the frame on latch.
  always @(negedge iODCK) begin
    if (iVSYNC_Preframe_rst) begin
      capN <= 0;
    end else begin
      if (bus.oSCLK && !sclkPrev && !bus.oCS_n && capN < 128) begin
        capBits[capN] <= bus.oSDO;
        capN          <= capN + 1;
      end
      if (bus.oLatch) begin
        frames.push_back('{nb: capN, bits: capBits});
        latchCnt <= latchCnt + 1;
        capN     <= 0;
      end
    end
    sclkPrev <= bus.oSCLK;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] byteAt(input logic [0:127] b, input int k);
    return b[8*k +: 8];
  endfunction

  function automatic logic [7:0] crcByte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = ((r[7] ^ d[i]) == 1'b1) ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic waitFrames(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (frames.size() < target && k < budget) begin
      @(negedge iODCK);
      k++;
    end
    chk({nm, ".arrived"}, 64'(frames.size() >= target), 64'd1);
  endtask

  task automatic checkFrame(input string nm, input int idx, input logic [3:0] r,
                            input logic [7:0] expHdr);
    frame_t     f;
    logic [7:0] c;
    if (idx >= frames.size()) return;
    f = frames[idx];
    chk({nm, ".nbits"}, 64'(f.nb), 64'(NB));
    chk({nm, ".hdr"}, 64'(byteAt(f.bits, 0)), 64'(expHdr));
    c = crcByte(8'h00, expHdr);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s.duty%0d", nm, k), 64'(byteAt(f.bits, k + 1)), 64'(mem[r][k]));
      c = crcByte(c, mem[r][k]);
    end
`ifdef V_ZONE_TX_CRC8_EN
    chk({nm, ".crc"}, 64'(byteAt(f.bits, 9)), 64'(c));
`endif
  endtask

  task automatic idleAddr(input int n);
    iV_Address = 4'd15;
    repeat (n) @(negedge iODCK);
  endtask

  typedef struct { logic [3:0] addr; logic [7:0] expHdr; logic [7:0] expD0; logic [7:0] expD7; } vec_t;
  vec_t vecs[3];

  initial begin
    int base, lat0, k;
    frame_t f;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++)
        mem[r][c] = 8'(r * 16 + c + 16);
    vecs[0] = '{4'd0,  8'hA0, 8'h10, 8'h17};
    vecs[1] = '{4'd7,  8'hA7, 8'h80, 8'h87};
    vecs[2] = '{4'd14, 8'hAE, 8'hF0, 8'hF7};

    repeat (3) @(negedge iODCK);
    chk("rst.cs_n",  64'(bus.oCS_n),    64'd1);
    chk("rst.sclk",  64'(bus.oSCLK),    64'd0);
    chk("rst.sdo",   64'(bus.oSDO),     64'd0);
    chk("rst.latch", 64'(bus.oLatch),   64'd0);
    chk("rst.rden",  64'(bus.oRd_En),   64'd0);
    chk("rst.addr",  64'(bus.oRd_Addr), 64'd0);
    chk("rst.busy",  64'(oBusy),        64'd0);
    chk("rst.ovr",   64'(oOverrun),     64'd0);
    iVSYNC_Preframe_rst = 1'b0;
    repeat (2) @(negedge iODCK);

    // Table-driven single frames.
    for (int v = 0; v < 3; v++) begin
      idleAddr(4);
      base = frames.size();
      lat0 = latchCnt;
      iV_Address = vecs[v].addr;
      waitFrames(base + 1, 1000, $sformatf("vec%0d", v));
      if (frames.size() > base) begin
        f = frames[base];
        chk($sformatf("vec%0d.d0", v), 64'(byteAt(f.bits, 1)), 64'(vecs[v].expD0));
        chk($sformatf("vec%0d.d7", v), 64'(byteAt(f.bits, 8)), 64'(vecs[v].expD7));
        checkFrame($sformatf("vec%0d", v), base, vecs[v].addr, vecs[v].expHdr);
      end
      repeat (3) @(negedge iODCK);
      chk($sformatf("vec%0d.latches", v), 64'(latchCnt - lat0), 64'd1);
      chk($sformatf("vec%0d.cs_after", v), 64'(bus.oCS_n), 64'd1);
      chk($sformatf("vec%0d.busy_after", v), 64'(oBusy), 64'd0);
    end

    // Holding an address yields one frame; leaving via blank and returning re-arms it.
    idleAddr(4);
    base = frames.size();
    iV_Address = 4'd3;
    repeat (5000) @(negedge iODCK);
    chk("hold.frames", 64'(frames.size() - base), 64'd1);
    idleAddr(4);
    chk("blank.noframe", 64'(frames.size() - base), 64'd1);
    iV_Address = 4'd3;
    waitFrames(base + 2, 1000, "rearm");
    checkFrame("rearm", base + 1, 4'd3, 8'hA3);

    // Two triggers during row 0: row 1 is displaced by row 2.
    idleAddr(4);
    base = frames.size();
    iV_Address = 4'd0;
    repeat (6) @(negedge iODCK);
    iV_Address = 4'd1;
    repeat (6) @(negedge iODCK);
    iV_Address = 4'd2;
    waitFrames(base + 2, 2000, "ovr");
    if (frames.size() >= base + 2) begin
      chk("ovr.hdr0", 64'(byteAt(frames[base].bits, 0)), 64'hA0);
      chk("ovr.hdr1", 64'(byteAt(frames[base + 1].bits, 0)), 64'hA2);
    end
    repeat (400) @(negedge iODCK);
    chk("ovr.count", 64'(frames.size() - base), 64'd2);
    chk("ovr.flag", 64'(oOverrun), 64'd1);

    // Reset clears overrun; a trigger landing in GAP starts the next frame with no overrun.
    iVSYNC_Preframe_rst = 1'b1;
    iV_Address = 4'd15;
    repeat (2) @(negedge iODCK);
    chk("rst2.ovr", 64'(oOverrun), 64'd0);
    iVSYNC_Preframe_rst = 1'b0;
    repeat (3) @(negedge iODCK);
    base = frames.size();
    iV_Address = 4'd4;
    k = 0;
    while (!bus.oLatch && k < 1000) begin
      @(negedge iODCK);
      k++;
    end
    chk("gap.latch_seen", 64'(bus.oLatch), 64'd1);
    @(negedge iODCK);
    chk("gap.busy", 64'(oBusy), 64'd0);
    iV_Address = 4'd5;
    waitFrames(base + 2, 1000, "gap");
    checkFrame("gap", base + 1, 4'd5, 8'hA5);
    chk("gap.ovr", 64'(oOverrun), 64'd0);

    // Reset in the middle of a frame.
    idleAddr(4);
    base = frames.size();
    lat0 = latchCnt;
    iV_Address = 4'd6;
    k = 0;
    while (capN < 30 && k < 1000) begin
      @(negedge iODCK);
      k++;
    end
    chk("midrst.reached30", 64'(capN >= 30), 64'd1);
    iVSYNC_Preframe_rst = 1'b1;
    #1;
    chk("midrst.cs_n", 64'(bus.oCS_n), 64'd1);
    chk("midrst.sclk", 64'(bus.oSCLK), 64'd0);
    chk("midrst.busy", 64'(oBusy), 64'd0);
    iV_Address = 4'd15;
    repeat (3) @(negedge iODCK);
    iVSYNC_Preframe_rst = 1'b0;
    repeat (20) @(negedge iODCK);
    chk("midrst.nolatch", 64'(latchCnt - lat0), 64'd0);
    iV_Address = 4'd6;
    waitFrames(base + 1, 1000, "postrst");
    checkFrame("postrst", base, 4'd6, 8'hA6);

    // All-zero row 0: frame length and (when enabled) trailing CRC byte.
    for (int c = 0; c < 8; c++) mem[0][c] = 8'h00;
    idleAddr(4);
    base = frames.size();
    iV_Address = 4'd0;
    waitFrames(base + 1, 1000, "zero");
    checkFrame("zero", base, 4'd0, 8'hA0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
